// File: rtl/param_accum_cpu.sv
// Parametrised accumulator CPU: two-process control FSM plus accumulator datapath,
// with an on-chip program memory that is loadable from the START state.
module param_accum_cpu #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          enter,
    input  logic [DW-1:0] Nin,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic          halt,
    output logic [DW-1:0] Nout,
    output logic          ovf,
    output logic [2:0]    IR75out,
    output logic [3:0]    StateNoout,
    output logic [AW-1:0] pc_out
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_INWAIT = 4'd3,
        S_INREL  = 4'd4,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] acc_reg, acc_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [DW-1:0] ir_reg, ir_next;
    logic          ovf_reg, ovf_next;

    logic [DW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [2:0]    opcode;
    logic [AW-1:0] addr;
    logic [DW-1:0] operand;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;

    assign opcode  = ir_reg[DW-1:DW-3];
    assign addr    = ir_reg[AW-1:0];
    assign operand = mem[addr];
    assign sum     = acc_reg + operand;
    assign diff    = acc_reg - operand;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        ovf_next   = ovf_reg;
        mem_we     = 1'b0;
        mem_waddr  = prog_addr;
        mem_wdata  = prog_data;
        case (state_reg)
            S_START: begin
                mem_we = prog_we;
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_next    = mem[pc_reg];
                pc_next    = pc_reg + AW'(1);
                state_next = S_DECODE;
            end
            // Execute state codes are 8 + opcode, so decode is a plain concatenation.
            S_DECODE: state_next = state_t'({1'b1, opcode});
            S_LOAD: begin
                acc_next   = operand;
                state_next = S_FETCH;
            end
            S_STORE: begin
                mem_we     = 1'b1;
                mem_waddr  = addr;
                mem_wdata  = acc_reg;
                state_next = S_FETCH;
            end
            S_ADD: begin
                acc_next   = sum;
                ovf_next   = (acc_reg[DW-1] == operand[DW-1]) && (sum[DW-1] != acc_reg[DW-1]);
                state_next = S_FETCH;
            end
            S_SUB: begin
                acc_next   = diff;
                ovf_next   = (acc_reg[DW-1] != operand[DW-1]) && (diff[DW-1] != acc_reg[DW-1]);
                state_next = S_FETCH;
            end
            S_INPUT: state_next = S_INWAIT;
            S_INWAIT: begin
                if (enter) begin
                    acc_next   = Nin;
                    state_next = S_INREL;
                end
            end
            // Wait for release so one held press feeds exactly one INPUT.
            S_INREL: if (!enter) state_next = S_FETCH;
            S_JZ: begin
                if (acc_reg == '0) pc_next = addr;
                state_next = S_FETCH;
            end
            S_JPOS: begin
                if (!acc_reg[DW-1] && (acc_reg != '0)) pc_next = addr;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_START;
            acc_reg   <= '0;
            pc_reg    <= '0;
            ir_reg    <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign halt       = (state_reg == S_HALT);
    assign Nout       = acc_reg;
    assign ovf        = ovf_reg;
    assign IR75out    = opcode;
    assign StateNoout = state_reg;
    assign pc_out     = pc_reg;

endmodule

// File: tb/tb_param_accum_cpu.sv
// Directed bench for param_accum_cpu: default 8/5 instance plus a 12/8 instance
// for the parameter sweep, with hand-computed expectations.
module tb_param_accum_cpu;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    // DW=8, AW=5 instance
    logic       reset = 1'b0, run = 1'b0, enter = 1'b0, prog_we = 1'b0;
    logic [7:0] Nin = '0, prog_data = '0;
    logic [4:0] prog_addr = '0;
    logic       halt, ovf;
    logic [7:0] Nout;
    logic [2:0] IR75out;
    logic [3:0] StateNoout;
    logic [4:0] pc_out;

    // DW=12, AW=8 instance
    logic        reset12 = 1'b0, run12 = 1'b0, enter12 = 1'b0, prog_we12 = 1'b0;
    logic [11:0] Nin12 = '0, prog_data12 = '0;
    logic [7:0]  prog_addr12 = '0;
    logic        halt12, ovf12;
    logic [11:0] Nout12;
    logic [2:0]  IR75out12;
    logic [3:0]  StateNoout12;
    logic [7:0]  pc_out12;

    int checks = 0;
    int errors = 0;
    int n;

    param_accum_cpu #(.DW(8), .AW(5)) dut (
        .clock(clock), .reset(reset), .run(run), .enter(enter), .Nin(Nin),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .halt(halt), .Nout(Nout), .ovf(ovf), .IR75out(IR75out),
        .StateNoout(StateNoout), .pc_out(pc_out)
    );

    param_accum_cpu #(.DW(12), .AW(8)) dut12 (
        .clock(clock), .reset(reset12), .run(run12), .enter(enter12), .Nin(Nin12),
        .prog_we(prog_we12), .prog_addr(prog_addr12), .prog_data(prog_data12),
        .halt(halt12), .Nout(Nout12), .ovf(ovf12), .IR75out(IR75out12),
        .StateNoout(StateNoout12), .pc_out(pc_out12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic prog8(input logic [4:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic prog12(input logic [7:0] a, input logic [11:0] d);
        prog_we12 = 1'b1; prog_addr12 = a; prog_data12 = d;
        tick();
        prog_we12 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic run_pulse();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Counts edges until halt; a missed halt is reported as a failed check.
    task automatic run_to_halt(output int cnt);
        cnt = 0;
        while (!halt && cnt < 300) begin
            tick();
            cnt++;
        end
        check("halt_reached", {31'd0, halt}, 32'd1);
    endtask

    task automatic load_add_prog();
        prog8(5'd0, 8'h0A);   // LOAD 10
        prog8(5'd1, 8'h4B);   // ADD 11
        prog8(5'd2, 8'h2C);   // STORE 12
        prog8(5'd3, 8'hE0);   // HALT
        prog8(5'd10, 8'd5);
        prog8(5'd11, 8'd7);
    endtask

    initial begin
        // Reset and idle
        tick(); tick();
        check("rst_state", {28'd0, StateNoout}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_state", {28'd0, StateNoout}, 32'd0);
            check("idle_nout", {24'd0, Nout}, 32'd0);
            check("idle_pc", {27'd0, pc_out}, 32'd0);
            check("idle_halt", {31'd0, halt}, 32'd0);
        end

        // Load and add: halt rises on the 12th edge counted from run
        load_add_prog();
        run_pulse();
        repeat (10) tick();
        check("la_halt_early", {31'd0, halt}, 32'd0);
        tick();
        check("la_halt", {31'd0, halt}, 32'd1);
        check("la_state", {28'd0, StateNoout}, 32'd15);
        check("la_nout", {24'd0, Nout}, 32'd12);
        check("la_pc", {27'd0, pc_out}, 32'd4);
        check("la_ir", {29'd0, IR75out}, 32'd7);
        check("la_ovf", {31'd0, ovf}, 32'd0);

        // Write attempted in HALT must be ignored; M0 stays LOAD 10
        prog8(5'd0, 8'hE0);
        enter = 1'b1; run = 1'b1;
        tick();
        check("halt_sticky", {28'd0, StateNoout}, 32'd15);
        enter = 1'b0; run = 1'b0;
        do_reset();
        prog8(5'd1, 8'hE0);
        run_pulse();
        run_to_halt(n);
        check("m0_kept_nout", {24'd0, Nout}, 32'd5);

        // STORE committed 12 into M12
        do_reset();
        prog8(5'd0, 8'h0C);   // LOAD 12
        prog8(5'd1, 8'hE0);
        run_pulse();
        run_to_halt(n);
        check("m12_nout", {24'd0, Nout}, 32'd12);

        // Input and loop
        do_reset();
        prog8(5'd0, 8'h80);   // INPUT
        prog8(5'd1, 8'h74);   // SUB 20
        prog8(5'd2, 8'hC1);   // JPOS 1
        prog8(5'd3, 8'hE0);   // HALT
        prog8(5'd20, 8'd1);
        Nin = 8'd3;
        run_pulse();
        n = 0;
        while (StateNoout != 4'd3 && n < 20) begin
            tick();
            n++;
        end
        check("inwait_reached", {28'd0, StateNoout}, 32'd3);
        enter = 1'b1;
        tick();
        check("in_latch", {24'd0, Nout}, 32'd3);
        check("in_rel", {28'd0, StateNoout}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("in_rel_hold", {28'd0, StateNoout}, 32'd4);
        end
        Nin = 8'd9;
        enter = 1'b0;
        tick();
        check("in_fetch", {28'd0, StateNoout}, 32'd1);
        check("in_nout_once", {24'd0, Nout}, 32'd3);
        run_to_halt(n);
        check("loop_cycles", n, 32'd20);
        check("loop_nout", {24'd0, Nout}, 32'd0);
        check("loop_ovf", {31'd0, ovf}, 32'd0);

        // Overflow and JZ
        do_reset();
        prog8(5'd0, 8'h14);   // LOAD 20
        prog8(5'd1, 8'h55);   // ADD 21
        prog8(5'd2, 8'hC6);   // JPOS 6
        prog8(5'd3, 8'h76);   // SUB 22
        prog8(5'd4, 8'hA7);   // JZ 7
        prog8(5'd5, 8'hE0);
        prog8(5'd6, 8'hE0);
        prog8(5'd7, 8'hE0);
        prog8(5'd20, 8'd127);
        prog8(5'd21, 8'd1);
        prog8(5'd22, 8'h80);
        run_pulse();
        repeat (3) tick();
        check("ov_load", {24'd0, Nout}, 32'd127);
        repeat (3) tick();
        check("ov_add", {24'd0, Nout}, 32'h80);
        check("ov_flag", {31'd0, ovf}, 32'd1);
        repeat (3) tick();
        check("jpos_not_taken", {27'd0, pc_out}, 32'd3);
        check("ov_hold", {31'd0, ovf}, 32'd1);
        repeat (3) tick();
        check("sub_nout", {24'd0, Nout}, 32'd0);
        check("sub_ovf", {31'd0, ovf}, 32'd0);
        repeat (3) tick();
        check("jz_taken", {27'd0, pc_out}, 32'd7);
        run_to_halt(n);
        check("jz_halt_pc", {27'd0, pc_out}, 32'd8);

        // PC wrap with all-LOAD-0 memory
        do_reset();
        for (int i = 0; i < 32; i++) prog8(5'(i), 8'h00);
        run_pulse();
        repeat (93) tick();
        check("wrap_pc31", {27'd0, pc_out}, 32'd31);
        check("wrap_fetch", {28'd0, StateNoout}, 32'd1);
        tick();
        check("wrap_pc0", {27'd0, pc_out}, 32'd0);
        check("wrap_decode", {28'd0, StateNoout}, 32'd2);

        // Reset during ADD execute
        do_reset();
        load_add_prog();
        run_pulse();
        n = 0;
        while (StateNoout != 4'd10 && n < 20) begin
            tick();
            n++;
        end
        check("mid_add_state", {28'd0, StateNoout}, 32'd10);
        check("mid_add_nout", {24'd0, Nout}, 32'd5);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {28'd0, StateNoout}, 32'd0);
        check("mid_rst_nout", {24'd0, Nout}, 32'd0);
        check("mid_rst_pc", {27'd0, pc_out}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_pulse();
        run_to_halt(n);
        check("rerun_cycles", n, 32'd11);
        check("rerun_nout", {24'd0, Nout}, 32'd12);
        do_reset();
        run_pulse();
        run_to_halt(n);
        check("rerun2_cycles", n, 32'd11);
        check("rerun2_nout", {24'd0, Nout}, 32'd12);

        // Parameter sweep: DW=12, AW=8
        reset12 = 1'b1;
        tick();
        check("w_rst_state", {28'd0, StateNoout12}, 32'd0);
        prog12(8'd0, 12'h00A);
        prog12(8'd1, 12'h40B);
        prog12(8'd2, 12'h20C);
        prog12(8'd3, 12'hE00);
        prog12(8'd10, 12'd5);
        prog12(8'd11, 12'd7);
        run12 = 1'b1;
        tick();
        run12 = 1'b0;
        repeat (10) tick();
        check("w_halt_early", {31'd0, halt12}, 32'd0);
        tick();
        check("w_halt", {31'd0, halt12}, 32'd1);
        check("w_nout", {20'd0, Nout12}, 32'd12);
        check("w_pc", {24'd0, pc_out12}, 32'd4);
        check("w_ir", {29'd0, IR75out12}, 32'd7);
        check("w_ovf", {31'd0, ovf12}, 32'd0);
        reset12 = 1'b0;
        tick();
        reset12 = 1'b1;
        prog12(8'd0, 12'h00C);
        prog12(8'd1, 12'hE00);
        run12 = 1'b1;
        tick();
        run12 = 1'b0;
        repeat (5) tick();
        check("w_m12_halt", {31'd0, halt12}, 32'd1);
        check("w_m12_nout", {20'd0, Nout12}, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
